fp_alu_cmd_issuer: RTL

- Hardware initiator for the fp_alu start/done interface; replaces the bench-style "drive operands, pulse start, wait done" sequence with RTL.
- Accepts tagged FP commands on a valid/ready channel and buffers them in a small FIFO.
- Issues commands to the ALU one at a time and returns result, flags and tag on a valid/ready response channel.
- Sits between a command source (CPU/DMA front end) and one fp_alu instance.

---
 rtl/fp_alu_cmd_issuer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/fp_alu_cmd_issuer.sv
// fp_alu_cmd_issuer: queues tagged FP commands, issues them one at a time to a
// single fp_alu over its start/done handshake, and returns result, flags and
// tag in command order. A WAIT that outlives TIMEOUT_CYCLES is closed with a
// qNaN result and the timeout flag so a hung ALU cannot stall the queue.
module fp_alu_cmd_issuer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      alu_operand_a,
    output logic [31:0]      alu_operand_b,
    output logic [1:0]       alu_operation,
    output logic             alu_start,
    input  logic [31:0]      alu_result,
    input  logic             alu_done,
    input  logic             alu_overflow,
    input  logic             alu_underflow,
    input  logic             alu_invalid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    typedef struct packed {
        logic [1:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    entry_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               full;
    logic               push;
    logic               pop;
    entry_t             cmd_entry;
    entry_t             head;

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign cmd_entry = '{op: cmd_op, a: cmd_a, b: cmd_b, tag: cmd_tag};
    assign head      = fifo_mem[rd_ptr_q];

    // Storage array: no reset, contents are only meaningful below count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= cmd_entry;
        end
    end

    // Pointers wrap naturally since FIFO_DEPTH is a power of two; a push and
    // a pop in the same cycle leave the occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    state_t             state_q;
    state_t             state_d;
    logic               tmo_clr;
    logic               tmo_inc;
    logic               cap_done;
    logic               cap_tmo;
    logic [15:0]        tmo_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath strobes. Done is only looked at in WAIT, so a
    // level-style done left over from the previous command is never taken
    // in the ISSUE cycle. Done wins over timeout on the last WAIT cycle.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        tmo_clr  = 1'b0;
        tmo_inc  = 1'b0;
        cap_done = 1'b0;
        cap_tmo  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmo_clr = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (alu_done) begin
                    cap_done = 1'b1;
                    state_d  = S_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    cap_tmo = 1'b1;
                    state_d = S_RESP;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand, timeout and response registers
    // ------------------------------------------------------------------
    logic [31:0]        op_a_q;
    logic [31:0]        op_b_q;
    logic [1:0]         op_sel_q;
    logic [TAG_W-1:0]   tag_q;
    logic [31:0]        rsp_result_q;
    logic [3:0]         rsp_flags_q;
    logic [TAG_W-1:0]   rsp_tag_q;

    // Operands load on pop and then hold through ISSUE/WAIT and while idle;
    // the response is latched once on leaving WAIT and held until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_sel_q     <= '0;
            tag_q        <= '0;
            tmo_q        <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_tag_q    <= '0;
        end else begin
            if (pop) begin
                op_a_q   <= head.a;
                op_b_q   <= head.b;
                op_sel_q <= head.op;
                tag_q    <= head.tag;
            end
            if (tmo_clr) begin
                tmo_q <= '0;
            end else if (tmo_inc) begin
                tmo_q <= tmo_q + 16'd1;
            end
            if (cap_done) begin
                rsp_result_q <= alu_result;
                rsp_flags_q  <= {1'b0, alu_invalid, alu_underflow, alu_overflow};
                rsp_tag_q    <= tag_q;
            end else if (cap_tmo) begin
                rsp_result_q <= QNAN;
                rsp_flags_q  <= 4'b1000;
                rsp_tag_q    <= tag_q;
            end
        end
    end

    assign alu_operand_a = op_a_q;
    assign alu_operand_b = op_b_q;
    assign alu_operation = op_sel_q;
    assign alu_start     = (state_q == S_ISSUE);
    assign rsp_valid     = (state_q == S_RESP);
    assign rsp_result    = rsp_result_q;
    assign rsp_flags     = rsp_flags_q;
    assign rsp_tag       = rsp_tag_q;
    assign busy          = (count_q != '0) || (state_q != S_IDLE);

endmodule
